icache: RTL and testbench

- Direct-mapped, read-only instruction cache in front of the fetch stage. It replaces the combinational instruction ROM lookup.
- Takes PCF from the PC register and returns the instruction combinationally on a hit, so the single-cycle fetch timing is preserved.
- On a miss it stalls fetch and refills one line from the backing instruction memory using a multi-beat valid handshake.
- `flush_i` invalidates every line, for reprogramming and fence.i.

---
 rtl/fetch_pkg.sv | 34 +++
 rtl/icache_array.sv | 47 ++++
 rtl/icache.sv | 126 ++++++++++++
 tb/tb_icache.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types, default geometry and address-split helpers for the instruction cache.
package fetch_pkg;

  typedef enum logic {IDLE, REFILL} icache_state_t;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_NUM_SETS       = 64;
  localparam int DEF_WORDS_PER_LINE = 4;

  localparam int OFFSET_W = $clog2(DEF_WORDS_PER_LINE) + 2;
  localparam int INDEX_W  = $clog2(DEF_NUM_SETS);
  localparam int TAG_W    = DEF_DATA_WIDTH - OFFSET_W - INDEX_W;

  // Helpers take the field widths so they serve any legal geometry; callers narrow the result.
  function automatic logic [DEF_DATA_WIDTH-1:0] get_word(input logic [DEF_DATA_WIDTH-1:0] addr,
                                                         input int word_w);
    logic [DEF_DATA_WIDTH-1:0] mask;
    mask = {DEF_DATA_WIDTH{1'b1}} << word_w;
    return (addr >> 2) & ~mask;
  endfunction

  function automatic logic [DEF_DATA_WIDTH-1:0] get_index(input logic [DEF_DATA_WIDTH-1:0] addr,
                                                          input int ofs_w, input int idx_w);
    logic [DEF_DATA_WIDTH-1:0] mask;
    mask = {DEF_DATA_WIDTH{1'b1}} << idx_w;
    return (addr >> ofs_w) & ~mask;
  endfunction

  function automatic logic [DEF_DATA_WIDTH-1:0] get_tag(input logic [DEF_DATA_WIDTH-1:0] addr,
                                                        input int ofs_w, input int idx_w);
    return addr >> (ofs_w + idx_w);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, word write, line tag/valid set, flush-all.
module icache_array #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_W        = 6,
  parameter int WORD_W         = 2,
  parameter int TAG_W          = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    rd_index,
  input  logic [WORD_W-1:0]     rd_word,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [WORD_W-1:0]     wr_word,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  set_en,
  input  logic [INDEX_W-1:0]    set_index,
  input  logic [TAG_W-1:0]      set_tag,
  input  logic                  flush
);

  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_q [NUM_SETS*WORDS_PER_LINE];

  // Flush wins over set so a line finishing under a pending flush ends up invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        valid_q <= '0;
    else if (flush)  valid_q <= '0;
    else if (set_en) valid_q[set_index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (set_en) tag_q[set_index] <= set_tag;
    if (wr_en)  data_q[{wr_index, wr_word}] <= wr_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_word}];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, stall-and-refill on miss.
module icache import fetch_pkg::*; #(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_SETS       = DEF_NUM_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PCF_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] InstrF_o,
  output logic                  StallF_o,
  output logic                  mem_req_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int OFS_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TG_W   = DATA_WIDTH - OFS_W - IDX_W;
  localparam logic [WORD_W-1:0]     LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);
  localparam logic [DATA_WIDTH-1:0] LINE_MASK = ~DATA_WIDTH'(WORDS_PER_LINE*4 - 1);

  icache_state_t         state_q, state_d;
  logic [WORD_W-1:0]     beat_q;
  logic [DATA_WIDTH-1:0] miss_addr_q;
  logic                  flush_pend_q;

  logic [IDX_W-1:0]      pc_index, miss_index;
  logic [WORD_W-1:0]     pc_word;
  logic [TG_W-1:0]       pc_tag, miss_tag;
  logic                  rd_valid, hit;
  logic [TG_W-1:0]       rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  stall_c, req_c, wr_en, set_en, flush_all;

  assign pc_index   = IDX_W'(get_index(PCF_i, OFS_W, IDX_W));
  assign pc_word    = WORD_W'(get_word(PCF_i, WORD_W));
  assign pc_tag     = TG_W'(get_tag(PCF_i, OFS_W, IDX_W));
  assign miss_index = IDX_W'(get_index(miss_addr_q, OFS_W, IDX_W));
  assign miss_tag   = TG_W'(get_tag(miss_addr_q, OFS_W, IDX_W));

  icache_array #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_SETS       (NUM_SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .INDEX_W        (IDX_W),
    .WORD_W         (WORD_W),
    .TAG_W          (TG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (pc_index),
    .rd_word   (pc_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_index  (miss_index),
    .wr_word   (beat_q),
    .wr_data   (mem_rdata_i),
    .set_en    (set_en),
    .set_index (miss_index),
    .set_tag   (miss_tag),
    .flush     (flush_all)
  );

  assign hit = rd_valid && (rd_tag == pc_tag);

  always_comb begin
    state_d   = state_q;
    stall_c   = 1'b0;
    req_c     = 1'b0;
    wr_en     = 1'b0;
    set_en    = 1'b0;
    flush_all = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c   = !hit;
        flush_all = flush_i;
        if (!hit) state_d = REFILL;
      end
      REFILL: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        if (mem_valid_i) begin
          wr_en = 1'b1;
          if (beat_q == LAST_BEAT) begin
            set_en    = 1'b1;
            flush_all = flush_pend_q || flush_i;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      miss_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        beat_q       <= '0;
        flush_pend_q <= 1'b0;
        if (!hit) miss_addr_q <= PCF_i & LINE_MASK;
      end else begin
        if (mem_valid_i) beat_q <= beat_q + WORD_W'(1);
        flush_pend_q <= set_en ? 1'b0 : (flush_pend_q || flush_i);
      end
    end
  end

  // Stall is forced low while reset is held so fetch is not frozen by the cleared valid bits.
  assign StallF_o   = rst && stall_c;
  assign mem_req_o  = req_c;
  assign mem_addr_o = miss_addr_q;
  assign InstrF_o   = hit ? rd_data : '0;

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache against a set/tag reference model of the cache.
module tb_icache;
  import fetch_pkg::*;

  localparam int NS    = DEF_NUM_SETS;
  localparam int WPL   = DEF_WORDS_PER_LINE;
  localparam int LIMIT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PCF_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] InstrF_o;
  logic        StallF_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  icache dut (
    .clk         (clk),
    .rst         (rst),
    .PCF_i       (PCF_i),
    .flush_i     (flush_i),
    .InstrF_o    (InstrF_o),
    .StallF_o    (StallF_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_valid_i (mem_valid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instr[$];
  logic [31:0] exp_refill[$];
  bit          fetch_pending = 1'b0;
  int          wait_cfg = 0;
  int          rbeat = 0;
  int          gap = 0;
  bit          m_valid[NS];
  int unsigned m_tag[NS];
  logic        req_prev = 1'b0;
  logic [31:0] cur_addr = '0;

  // Backing memory image: the 0x10 line holds A0..A3, everything else a per-address hash.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a >= 32'h10 && a <= 32'h1C) return 32'hA0 + ((a - 32'h10) >> 2);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: wait_cfg idle cycles before every beat, noise on mem_valid_i while idle.
  always @(negedge clk) begin
    if (!rst || !mem_req_o) begin
      rbeat       = 0;
      gap         = wait_cfg;
      mem_valid_i = rst ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata_i = $urandom;
    end else if (gap > 0) begin
      gap--;
      mem_valid_i = 1'b0;
      mem_rdata_i = $urandom;
    end else begin
      mem_valid_i = 1'b1;
      mem_rdata_i = mem_val(mem_addr_o + 32'(rbeat * 4));
      rbeat++;
      gap = wait_cfg;
    end
  end

  // Monitor: refill requests and delivered instructions are popped from the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req_o && !req_prev) begin
        if (exp_refill.size() == 0) begin
          checks++; errors++;
          $display("FAIL refill_unexpected: got addr %h expected no refill", mem_addr_o);
        end else check("refill_addr", mem_addr_o, exp_refill.pop_front());
        cur_addr = mem_addr_o;
      end else if (mem_req_o) check("refill_addr_stable", mem_addr_o, cur_addr);
      if (!StallF_o) check("no_req_when_not_stalled", {31'b0, mem_req_o}, 32'd0);
      if (fetch_pending && !StallF_o) begin
        if (exp_instr.size() == 0) begin
          checks++; errors++;
          $display("FAIL instr_unexpected: got %h expected nothing", InstrF_o);
        end else check("instr", InstrF_o, exp_instr.pop_front());
        fetch_pending = 1'b0;
      end
    end
    req_prev = rst ? mem_req_o : 1'b0;
  end

  task automatic model_invalidate();
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
  endtask

  // Issue one fetch; fcyc>0 pulses flush_i in that cycle if the fetch misses.
  task automatic fetch(input logic [31:0] a, input int fcyc);
    int          idx, n, r, cyc, fc;
    int unsigned tg;
    logic [31:0] line;
    idx  = int'((a >> OFFSET_W) % NS);
    tg   = (a >> (OFFSET_W + INDEX_W)) & ((32'd1 << TAG_W) - 1);
    line = a & ~32'(WPL * 4 - 1);
    r    = WPL * (wait_cfg + 1);
    fc   = -1;
    if (m_valid[idx] && m_tag[idx] == tg) n = 0;
    else if (fcyc > 0) begin n = 2; fc = fcyc; end
    else n = 1;
    for (int i = 0; i < n; i++) exp_refill.push_back(line);
    if (n == 2) model_invalidate();
    if (n > 0) begin m_valid[idx] = 1'b1; m_tag[idx] = tg; end
    exp_instr.push_back(mem_val(a & ~32'h3));
    PCF_i = a;
    fetch_pending = 1'b1;
    cyc = 0;
    while (fetch_pending && cyc < LIMIT) begin
      flush_i = (cyc == fc);
      @(posedge clk); #1;
      cyc++;
    end
    flush_i = 1'b0;
    if (fetch_pending) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: pc %h still stalled after %0d cycles", a, cyc);
      fetch_pending = 1'b0;
      exp_instr.delete();
    end else check("stall_cycles", 32'(cyc - 1), 32'(n * (r + 1)));
  endtask

  task automatic flush_idle();
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_cycle_lookup_hits", {31'b0, StallF_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    model_invalidate();
  endtask

  initial begin
    int k;
    model_invalidate();
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {31'b0, StallF_o}, 32'd0);
    check("reset_req", {31'b0, mem_req_o}, 32'd0);
    check("reset_addr", mem_addr_o, 32'd0);
    check("reset_instr", InstrF_o, 32'd0);

    rst = 1'b1;
    fetch(32'h10, -1);
    fetch(32'h14, -1);
    fetch(32'h18, -1);
    fetch(32'h1C, -1);

    fetch(32'h410, -1);
    fetch(32'h10, -1);

    wait_cfg = 2;
    fetch(32'h820, -1);
    fetch(32'h824, -1);
    fetch(32'h828, -1);
    fetch(32'h82C, -1);
    wait_cfg = 0;

    flush_idle();
    fetch(32'h10, -1);
    fetch(32'h20, 2);

    // Reset in the middle of a refill, after beat 1 has been delivered.
    exp_refill.push_back(32'h10);
    PCF_i = 32'h10;
    k = 0;
    do begin @(negedge clk); #1; k++; end while (rbeat < 2 && k < 50);
    if (k >= 50) begin
      checks++; errors++;
      $display("FAIL reset_refill_timeout: got beat %0d expected 2", rbeat);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midreset_req", {31'b0, mem_req_o}, 32'd0);
    check("midreset_stall", {31'b0, StallF_o}, 32'd0);
    model_invalidate();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    fetch(32'h10, -1);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int fc;
      wait_cfg = $urandom_range(0, 2);
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      fc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WPL * (wait_cfg + 1)) : -1;
      if ($urandom_range(0, 19) == 0) flush_idle();
      fetch(a, fc);
    end

    check("refill_queue_drained", 32'(exp_refill.size()), 32'd0);
    check("instr_queue_drained", 32'(exp_instr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
